// File: rtl/uart_tx_fifo_drain.sv
// Reader end of the TX byte FIFO: pops one word per frame and shifts it out
// as a start bit, D_WIDTH data bits (LSB first) and STOP_BITS stop bits.
module uart_tx_fifo_drain #(
    parameter int D_WIDTH      = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tx_en,
    input  logic               fifo_empty,
    input  logic [D_WIDTH-1:0] fifo_rd_data,
    output logic               fifo_rd,
    output logic               tx,
    output logic               busy,
    output logic               tx_done_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(D_WIDTH + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PEN   = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] DATA_LAST = BW'(D_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic [D_WIDTH-1:0] shreg;
    logic [D_WIDTH-1:0] shreg_next;
    logic [CW-1:0]      clk_cnt;
    logic [BW-1:0]      bit_cnt;
    logic               cnt_last;

    assign shreg_next = shreg >> 1;
    assign cnt_last   = (clk_cnt == CNT_LAST);

    // tx is driven one bit ahead: each transition edge loads the level the
    // line must carry in the next bit period, keeping every output registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            shreg        <= '0;
            clk_cnt      <= '0;
            bit_cnt      <= '0;
            tx           <= 1'b1;
            fifo_rd      <= 1'b0;
            busy         <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            fifo_rd      <= 1'b0;
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (tx_en && !fifo_empty) begin
                        shreg   <= fifo_rd_data;
                        fifo_rd <= 1'b1;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt_last) begin
                        clk_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        clk_cnt <= '0;
                        shreg   <= shreg_next;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg_next[0];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // bit_cnt is reused here to count stop bits
                    if (cnt_last) begin
                        clk_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                        if (clk_cnt == CNT_PEN && bit_cnt == STOP_LAST) begin
                            tx_done_tick <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Drives two drain instances (one and two stop bits) from bench FIFOs and
// checks every cycle against a frame-position model plus a bench receiver.
module tb_uart_tx_fifo_drain;

    localparam int CPB = 4;
    localparam int SB0 = 1;
    localparam int SB1 = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_en = 1'b0;
    logic [1:0] fe;
    logic [1:0] rd;
    logic [1:0] txw;
    logic [1:0] bsy;
    logic [1:0] done;
    logic [7:0] fdata [2];

    logic [7:0] fmem [2][256];
    int         head [2];
    int         tail [2];
    int         pushed = 0;

    int         pos [2];
    logic [7:0] cur [2];
    logic [7:0] mlog [2][256];
    int         log_cnt [2];

    int         pops [2];
    logic [1:0] prev_busy = 2'b00;
    int         run_len [2];
    int         last_len [2];
    int         idle_run [2];
    int         last_gap [2];

    logic [1:0] rx_on = 2'b00;
    int         rx_cnt [2];
    logic [7:0] rx_byte [2];
    int         rx_idx [2];

    int         checks = 0;
    int         errors = 0;

    assign fe[0]    = (head[0] == tail[0]);
    assign fe[1]    = (head[1] == tail[1]);
    assign fdata[0] = fmem[0][head[0]];
    assign fdata[1] = fmem[1][head[1]];

    uart_tx_fifo_drain #(.D_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(SB0)) dut0 (
        .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .fifo_empty(fe[0]),
        .fifo_rd_data(fdata[0]), .fifo_rd(rd[0]), .tx(txw[0]), .busy(bsy[0]),
        .tx_done_tick(done[0])
    );

    uart_tx_fifo_drain #(.D_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(SB1)) dut1 (
        .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .fifo_empty(fe[1]),
        .fifo_rd_data(fdata[1]), .fifo_rd(rd[1]), .tx(txw[1]), .busy(bsy[1]),
        .tx_done_tick(done[1])
    );

    always #5 clk = ~clk;

    function automatic int flen(input int i);
        return (9 + ((i == 0) ? SB0 : SB1)) * CPB;
    endfunction

    // Line level at cycle p (1-based) of a frame carrying byte b
    function automatic logic exp_tx(input int p, input logic [7:0] b);
        int k;
        k = (p - 1) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        for (int i = 0; i < 2; i++) begin
            fmem[i][tail[i]] = b;
            tail[i] = tail[i] + 1;
        end
        pushed++;
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait expired, got timeout, expected event at t=%0t", name, $time);
    endtask

    task automatic waitBusy(input int i, input int budget);
        int n = 0;
        while (!bsy[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bsy[i]) timeoutFail("wait_busy");
    endtask

    task automatic waitFramesEnd(input int budget);
        int n = 0;
        while ((pos[0] != 0 || pos[1] != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pos[0] != 0 || pos[1] != 0) timeoutFail("wait_frame_end");
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (!(fe == 2'b11 && pos[0] == 0 && pos[1] == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(fe == 2'b11 && pos[0] == 0 && pos[1] == 0)) timeoutFail("wait_drain");
    endtask

    // Model: a frame occupies L cycles after the pop edge, then one IDLE
    // cycle must pass before the next pop can be decided.
    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                pos[i] <= 0;
            end else if (pos[i] == 0) begin
                if (tx_en && head[i] != tail[i]) begin
                    pos[i]              <= 1;
                    cur[i]              <= fmem[i][head[i]];
                    mlog[i][log_cnt[i]] <= fmem[i][head[i]];
                    log_cnt[i]          <= log_cnt[i] + 1;
                end
            end else if (pos[i] == flen(i)) begin
                pos[i] <= 0;
            end else begin
                pos[i] <= pos[i] + 1;
            end
        end
    end

    // Per-cycle compare, bench receiver, FIFO pop handling and busy timing
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int exp_v;
            int act_v;
            if (pos[i] == 0) exp_v = 8;
            else exp_v = {28'd0, exp_tx(pos[i], cur[i]), 1'b1, (pos[i] == 1), (pos[i] == flen(i))};
            act_v = {28'd0, txw[i], bsy[i], rd[i], done[i]};
            checkOutput((i == 0) ? "outputs_sb1" : "outputs_sb2", act_v, exp_v);

            if (!reset_n) begin
                rx_on[i]  <= 1'b0;
                rx_idx[i] <= log_cnt[i];
            end else if (!rx_on[i]) begin
                if (!txw[i]) begin
                    rx_on[i]  <= 1'b1;
                    rx_cnt[i] <= 1;
                end
            end else begin
                rx_cnt[i] <= rx_cnt[i] + 1;
                for (int b = 0; b < 8; b++) begin
                    if (rx_cnt[i] == CPB * (b + 1) + CPB / 2) rx_byte[i][b] <= txw[i];
                end
                if (rx_cnt[i] == 9 * CPB + CPB / 2) begin
                    checkOutput("rx_stop_bit", int'(txw[i]), 1);
                    checkOutput("rx_byte", int'(rx_byte[i]), int'(mlog[i][rx_idx[i]]));
                    rx_idx[i] <= rx_idx[i] + 1;
                    rx_on[i]  <= 1'b0;
                end
            end

            if (rd[i]) begin
                pops[i] <= pops[i] + 1;
                head[i] <= head[i] + 1;
            end

            if (bsy[i]) begin
                if (!prev_busy[i]) begin
                    last_gap[i] <= idle_run[i];
                    run_len[i]  <= 1;
                end else begin
                    run_len[i] <= run_len[i] + 1;
                end
            end else begin
                if (prev_busy[i]) begin
                    last_len[i] <= run_len[i];
                    idle_run[i] <= 1;
                end else begin
                    idle_run[i] <= idle_run[i] + 1;
                end
            end
            prev_busy[i] <= bsy[i];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] seq;
        logic [9:0] exp_seq;
        int p0;
        int p1;

        for (int i = 0; i < 2; i++) begin
            idle_run[i] = 1000;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_tx", int'(txw[i]), 1);
            checkOutput("reset_busy", int'(bsy[i]), 0);
            checkOutput("reset_rd", int'(rd[i]), 0);
            checkOutput("reset_done", int'(done[i]), 0);
        end
        reset_n = 1'b1;
        tx_en   = 1'b1;

        $display("[TB] idle with empty FIFO");
        repeat (100) @(negedge clk);
        checkOutput("idle_pops_sb1", pops[0], 0);
        checkOutput("idle_pops_sb2", pops[1], 0);
        checkOutput("idle_tx", int'(txw), 3);

        $display("[TB] single frame 0xA5");
        applyStimulus(8'hA5);
        waitBusy(0, 10);
        seq[0] = txw[0];
        for (int j = 1; j < 10; j++) begin
            repeat (CPB) @(negedge clk);
            seq[j] = txw[0];
        end
        exp_seq = 10'b1101001010;
        checkOutput("a5_bit_sequence", int'(seq), int'(exp_seq));
        waitDrain(200);
        repeat (2) @(negedge clk);
        checkOutput("a5_len_sb1", last_len[0], 40);
        checkOutput("a5_len_sb2", last_len[1], 44);
        checkOutput("a5_pops", pops[0] + pops[1], 2);

        $display("[TB] frame 0x00");
        applyStimulus(8'h00);
        waitDrain(200);
        repeat (2) @(negedge clk);
        checkOutput("zero_len_sb2", last_len[1], 44);

        $display("[TB] burst 01 FF 3C");
        p0 = pops[0];
        p1 = pops[1];
        applyStimulus(8'h01);
        applyStimulus(8'hFF);
        applyStimulus(8'h3C);
        waitDrain(500);
        repeat (2) @(negedge clk);
        checkOutput("burst_pops_sb1", pops[0] - p0, 3);
        checkOutput("burst_pops_sb2", pops[1] - p1, 3);
        checkOutput("burst_gap_sb1", last_gap[0], 1);
        checkOutput("burst_gap_sb2", last_gap[1], 1);

        $display("[TB] tx_en dropped mid-frame");
        applyStimulus(8'h55);
        applyStimulus(8'hAA);
        waitBusy(0, 10);
        repeat (20) @(negedge clk);
        tx_en = 1'b0;
        waitFramesEnd(200);
        repeat (30) @(negedge clk);
        checkOutput("held_fifo_sb1", tail[0] - head[0], 1);
        checkOutput("held_fifo_sb2", tail[1] - head[1], 1);
        checkOutput("held_busy", int'(bsy), 0);
        tx_en = 1'b1;
        @(negedge clk);
        checkOutput("resume_busy", int'(bsy), 3);
        checkOutput("resume_rd", int'(rd), 3);
        waitDrain(200);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0 && pushed < 200) applyStimulus(8'($urandom));
            if ($urandom_range(0, 199) == 0) tx_en = ~tx_en;
        end
        tx_en = 1'b1;
        waitDrain(20000);

        $display("[TB] reset during data bit 3");
        applyStimulus(8'hC3);
        applyStimulus(8'h5A);
        waitBusy(0, 10);
        repeat (17) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_tx", int'(txw), 3);
        checkOutput("async_reset_busy", int'(bsy), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        waitDrain(500);
        repeat (60) @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            checkOutput("final_pops", pops[i], pushed);
            checkOutput("final_frames", log_cnt[i], pushed);
            checkOutput("final_rx", rx_idx[i], log_cnt[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
